// File: rtl/fpu_lzd_share_ctrl.sv
// Round-robin share of one combinational LZD between add/sub normaliser (req 0) and I2F (req 1).
// IDLE->CALC->RESP, 2 cycles handshake-to-resp_valid; optional grant/stall counters under FPU_LZD_SHARE_STAT_EN.
module fpu_lzd_share_ctrl #(
  parameter int W     = 64,
  parameter int POS_W = $clog2(W) + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_data,
  output logic [W-1:0]     lzd_in,
  input  logic [POS_W-1:0] lzd_cnt,
  input  logic             lzd_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [POS_W-1:0] resp_cnt,
  output logic             resp_zero
`ifdef FPU_LZD_SHARE_STAT_EN
  ,
  output logic [15:0]      stat_gnt0,
  output logic [15:0]      stat_gnt1,
  output logic [15:0]      stat_stall
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  state_t           r_state;
  logic             r_rr_ptr;
  logic             r_id;
  logic [W-1:0]     r_op;
  logic             r_resp_vld;
  logic             r_resp_id;
  logic [POS_W-1:0] r_resp_cnt;
  logic             r_resp_zero;

  logic             w_idle;
  logic             w_win;
  logic             w_gnt0;
  logic             w_gnt1;

  // Readys are combinational from state, so gate them while reset is asserted.
  assign w_idle = (r_state == S_IDLE) && rst_l;
  assign w_win  = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
  assign w_gnt0 = w_idle && req0_valid && !w_win;
  assign w_gnt1 = w_idle && req1_valid && w_win;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign lzd_in     = r_op;
  assign resp_valid = r_resp_vld;
  assign resp_id    = r_resp_id;
  assign resp_cnt   = r_resp_cnt;
  assign resp_zero  = r_resp_zero;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 1'b0;
      r_id        <= 1'b0;
      r_op        <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_id   <= 1'b0;
      r_resp_cnt  <= '0;
      r_resp_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_op     <= w_gnt1 ? req1_data : req0_data;
            r_id     <= w_gnt1;
            r_rr_ptr <= ~w_gnt1;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_resp_cnt  <= lzd_zero ? POS_W'(W) : lzd_cnt;
          r_resp_zero <= lzd_zero;
          r_resp_id   <= r_id;
          r_resp_vld  <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_vld <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_resp_vld <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FPU_LZD_SHARE_STAT_EN
  logic w_stall;
  assign w_stall = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      stat_gnt0  <= '0;
      stat_gnt1  <= '0;
      stat_stall <= '0;
    end else begin
      if (w_gnt0 && stat_gnt0 != 16'hFFFF)
        stat_gnt0 <= stat_gnt0 + 16'd1;
      if (w_gnt1 && stat_gnt1 != 16'hFFFF)
        stat_gnt1 <= stat_gnt1 + 16'd1;
      if (w_stall && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_lzd_share_ctrl.sv
// Directed bench for fpu_lzd_share_ctrl; the shared LZD is modelled here and reports count 0 for a zero operand.
module tb_fpu_lzd_share_ctrl;
  localparam int W     = 64;
  localparam int POS_W = 7;

  logic             clk;
  logic             rst_l;
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_data;
  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_data;
  logic [W-1:0]     lzd_in;
  logic [POS_W-1:0] lzd_cnt;
  logic             lzd_zero;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [POS_W-1:0] resp_cnt;
  logic             resp_zero;
`ifdef FPU_LZD_SHARE_STAT_EN
  logic [15:0]      stat_gnt0;
  logic [15:0]      stat_gnt1;
  logic [15:0]      stat_stall;
`endif

  int n_assert;
  int n_fail;

  fpu_lzd_share_ctrl #(.W(W), .POS_W(POS_W)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .lzd_in     (lzd_in),
    .lzd_cnt    (lzd_cnt),
    .lzd_zero   (lzd_zero),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_cnt   (resp_cnt),
    .resp_zero  (resp_zero)
`ifdef FPU_LZD_SHARE_STAT_EN
    ,
    .stat_gnt0  (stat_gnt0),
    .stat_gnt1  (stat_gnt1),
    .stat_stall (stat_stall)
`endif
  );

  function automatic logic [POS_W-1:0] lzc(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--)
      if (v[i]) return POS_W'(W - 1 - i);
    return '0;
  endfunction

  assign lzd_cnt  = lzc(lzd_in);
  assign lzd_zero = (lzd_in == '0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_l      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 64'h0000_0000_0000_0100;
    req1_data  = 64'h0;
    resp_ready = 1'b0;

    // Reset held with both requesters valid
    repeat (3) @(negedge clk);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_cnt", resp_cnt, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_zero", resp_zero, 0);
    chk("rst_lzd_in", lzd_in, 0);

    // Release: req0 wins the first tie
    rst_l = 1'b1;
    #1;
    chk("rel_rdy0", req0_ready, 1);
    chk("rel_rdy1", req1_ready, 0);
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    chk("calc_rdy0", req0_ready, 0);
    chk("calc_resp_valid", resp_valid, 0);
    chk("calc_lzd_in", lzd_in, 64'h0000_0000_0000_0100);
    @(negedge clk);
    chk("single_valid", resp_valid, 1);
    chk("single_id", resp_id, 0);
    chk("single_cnt", resp_cnt, 55);
    chk("single_zero", resp_zero, 0);
    @(negedge clk);
    chk("single_done", resp_valid, 0);

    // Zero operand from req1
    req1_valid = 1'b1;
    req1_data  = 64'h0;
    #1;
    chk("zero_rdy1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("zero_valid", resp_valid, 1);
    chk("zero_id", resp_id, 1);
    chk("zero_cnt", resp_cnt, 64);
    chk("zero_flag", resp_zero, 1);
    @(negedge clk);

    // Contention: grants alternate, one every 3 cycles
    req0_data  = 64'h8000_0000_0000_0000;
    req1_data  = 64'h0000_0000_0000_0001;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_rdy0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_rdy1", req1_ready, (i % 2 == 1) ? 1 : 0);
      @(negedge clk);
      chk("cont_calc_rdy", {req1_ready, req0_ready}, 0);
      @(negedge clk);
      chk("cont_valid", resp_valid, 1);
      chk("cont_id", resp_id, (i % 2 == 1) ? 1 : 0);
      chk("cont_cnt", resp_cnt, (i % 2 == 1) ? 63 : 0);
      @(negedge clk);
    end

    // Backpressure: response held for 5 cycles
    resp_ready = 1'b0;
    req0_data  = 64'h0000_FFFF_0000_0000;
    #1;
    chk("bp_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_data = 64'h0000_0000_0000_0001;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_id", resp_id, 0);
      chk("bp_cnt", resp_cnt, 16);
      chk("bp_zero", resp_zero, 0);
      chk("bp_rdy", {req1_ready, req0_ready}, 0);
      if (i < 4) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_rdy1", req1_ready, 1);
    chk("bp_lzd_hold", lzd_in, 64'h0000_FFFF_0000_0000);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("bp_idle_rdy", {req1_ready, req0_ready}, 0);

    // Reset while in CALC
    req1_valid = 1'b1;
    req1_data  = 64'h0000_0000_0000_0001;
    #1;
    chk("mid_rdy1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    chk("mid_lzd_in", lzd_in, 64'h0000_0000_0000_0001);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_resp", resp_valid, 0);
`ifdef FPU_LZD_SHARE_STAT_EN
      if (i == 0) begin
        chk("mid_stat_gnt0", stat_gnt0, 0);
        chk("mid_stat_gnt1", stat_gnt1, 0);
        chk("mid_stat_stall", stat_stall, 0);
      end
`endif
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("mid_rr_rdy0", req0_ready, 1);
    chk("mid_rr_rdy1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
